// File: rtl/lzc_expander_pkg.sv
// Shared types and helpers for the leading-zero count / expand datapath.
package lzc_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} lzc_exp_state_t;

    function automatic int lzc_count_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/lzc_expander_if.sv
// Input-triple and result handshake bundle for lzc_expander.
interface lzc_expander_if #(
    parameter int WIDTH = 16,
    parameter int COUNT = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_mant;
    logic [COUNT-1:0] in_z;
    logic             in_n_v;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_err;

    modport master (
        output in_valid, in_mant, in_z, in_n_v, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_mant, in_z, in_n_v, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/lzc_expander_rshift_step.sv
// One conditional right-shift step: by 2**k when the selected count bit is set.
module lzc_rshift_step #(
    parameter int WIDTH = 16,
    parameter int COUNT = 4
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic [COUNT-1:0] k_i,
    input  logic             zbit_i,
    output logic [WIDTH-1:0] acc_o
);
    logic [COUNT-1:0][WIDTH-1:0] shifted;
    logic [WIDTH-1:0]            sel;

    for (genvar i = 0; i < COUNT; i++) begin : g_sh
        localparam int SH = 1 << i;
        assign shifted[i] = acc_i >> SH;
    end

    always_comb begin
        sel = acc_i;
        for (int i = 0; i < COUNT; i++) begin
            if (k_i == COUNT'(i)) sel = shifted[i];
        end
    end

    assign acc_o = zbit_i ? sel : acc_i;
endmodule

// File: rtl/lzc_expander.sv
// Sequential de-normalizer: rebuilds mant >> z over COUNT single-step cycles.
module lzc_expander
    import lzc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    lzc_expander_if.slave bus
);
    localparam int COUNT = lzc_count_w(WIDTH);

    if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("lzc_expander: WIDTH must be a power of 2 and >= 2");
    end

    lzc_exp_state_t   state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d, acc_step;
    logic [COUNT-1:0] zreg_q, zreg_d;
    logic [COUNT-1:0] k_q, k_d;
    logic             err_q, err_d;
    logic             accept;

    lzc_rshift_step #(.WIDTH(WIDTH), .COUNT(COUNT)) u_step (
        .acc_i  (acc_q),
        .k_i    (k_q),
        .zbit_i (zreg_q[k_q]),
        .acc_o  (acc_step)
    );

    assign accept = (state_q == IDLE) && bus.in_valid;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        zreg_d  = zreg_q;
        k_d     = k_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (accept) begin
                acc_d   = bus.in_n_v ? bus.in_mant : '0;
                zreg_d  = bus.in_z;
                err_d   = bus.in_n_v & ~bus.in_mant[WIDTH-1];
                k_d     = '0;
                state_d = bus.in_n_v ? SHIFT : DONE;
            end
            SHIFT: begin
                acc_d = acc_step;
                k_d   = k_q + 1'b1;
                if (k_q == COUNT'(COUNT - 1)) state_d = DONE;
            end
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            zreg_q  <= '0;
            k_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            zreg_q  <= zreg_d;
            k_q     <= k_d;
            err_q   <= err_d;
        end
    end

    // Outputs are gated to DONE so a stale result never leaks out of IDLE/SHIFT.
    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = (state_q == DONE) ? acc_q : '0;
    assign bus.out_err   = (state_q == DONE) && err_q;
endmodule

// File: tb/tb_lzc_expander.sv
// Randomized self-checking bench for lzc_expander against a shift/normalize model.
module tb_lzc_expander;
    localparam int W = 16;
    localparam int C = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    lzc_expander_if #(.WIDTH(W)) bus ();
    lzc_expander #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: expected expansion straight from the definition.
    function automatic logic [W-1:0] ref_out(input logic [W-1:0] m, input int z, input logic nv);
        return nv ? (m >> z) : '0;
    endfunction

    function automatic int ref_lz(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) if (w[i]) return W - 1 - i;
        return W;
    endfunction

    task automatic run_txn(input logic [W-1:0] m, input logic [C-1:0] z, input logic nv,
                           output logic [W-1:0] d, output logic e, output int lat, output int rdy_hi);
        int guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        bus.in_valid = 1'b1;
        bus.in_mant  = m;
        bus.in_z     = z;
        bus.in_n_v   = nv;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_mant  = W'($urandom);
        bus.in_z     = C'($urandom);
        lat = 0;
        rdy_hi = 0;
        while (lat < 50) begin
            @(negedge clk);
            lat++;
            if (bus.in_ready) rdy_hi++;
            if (bus.out_valid) break;
        end
        d = bus.out_data;
        e = bus.out_err;
    endtask

    logic [W-1:0] d, w, m, d0;
    logic         e, e0, nv;
    logic [C-1:0] z;
    int           lat, rh, lz;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_mant   = '0;
        bus.in_z      = '0;
        bus.in_n_v    = 1'b0;
        bus.out_ready = 1'b1;

        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_data", 32'(bus.out_data), 0);
        chk("rst_out_err", 32'(bus.out_err), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 32'(bus.in_ready), 1);

        // Directed corner cases.
        run_txn(16'h8000, 4'd0, 1'b1, d, e, lat, rh);
        chk("sh0_data", 32'(d), 32'h8000);
        chk("sh0_err", 32'(e), 0);
        chk("sh0_lat", lat, C + 1);
        chk("sh0_rdy", rh, 0);

        run_txn(16'h8000, 4'd15, 1'b1, d, e, lat, rh);
        chk("sh15_data", 32'(d), 32'h0001);

        run_txn(16'hB400, 4'd3, 1'b1, d, e, lat, rh);
        chk("sh3_data", 32'(d), 32'h1680);

        run_txn(16'hFFFF, 4'd7, 1'b0, d, e, lat, rh);
        chk("zero_data", 32'(d), 0);
        chk("zero_lat", lat, 1);
        chk("zero_rdy_low", 32'(bus.in_ready), 0);
        @(negedge clk);
        chk("zero_rdy_back", 32'(bus.in_ready), 1);

        // Error flag plus consumer stall.
        bus.out_ready = 1'b0;
        run_txn(16'h4000, 4'd2, 1'b1, d0, e0, lat, rh);
        chk("err_data", 32'(d0), 32'h1000);
        chk("err_flag", 32'(e0), 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(bus.out_valid), 1);
            chk("stall_data", 32'(bus.out_data), 32'(d0));
            chk("stall_err", 32'(bus.out_err), 32'(e0));
            chk("stall_rdy", 32'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("post_hs_valid", 32'(bus.out_valid), 0);
        chk("post_hs_rdy", 32'(bus.in_ready), 1);

        // Reset in the middle of SHIFT.
        bus.in_valid = 1'b1;
        bus.in_mant  = 16'hC000;
        bus.in_z     = 4'd5;
        bus.in_n_v   = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 32'(bus.out_valid), 0);
        chk("mid_rst_data", 32'(bus.out_data), 0);
        chk("mid_rst_rdy", 32'(bus.in_ready), 1);
        run_txn(16'hA5A5, 4'd4, 1'b1, d, e, lat, rh);
        chk("after_rst_data", 32'(d), 32'h0A5A);
        chk("after_rst_lat", lat, C + 1);

        // Random triples, including zero words and malformed mantissas.
        for (int i = 0; i < 200; i++) begin
            m  = W'($urandom);
            z  = C'($urandom);
            nv = ($urandom_range(0, 7) != 0);
            run_txn(m, z, nv, d, e, lat, rh);
            chk("rnd_data", 32'(d), 32'(ref_out(m, int'(z), nv)));
            chk("rnd_err", 32'(e), 32'(nv & ~m[W-1]));
            chk("rnd_lat", lat, nv ? C + 1 : 1);
        end

        // Round trip through a normalize model.
        for (int i = 0; i < 1000; i++) begin
            do w = W'($urandom); while (w == '0);
            lz = ref_lz(w);
            m  = w << lz;
            run_txn(m, C'(lz), 1'b1, d, e, lat, rh);
            chk("rt_data", 32'(d), 32'(w));
            chk("rt_err", 32'(e), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
